debounce_arbiter: RTL and testbench



---
 rtl/debounce_pkg.sv | 39 +++
 rtl/debounce_rr_picker.sv | 58 +++++
 rtl/debounce_arbiter.sv | 156 +++++++++++++++
 tb/tb_debounce_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
//
// Purpose:
//   Shared definitions for the debounce blocks: the FSM state encoding used by
//   the time-shared debounce arbiter, and the default stability-counter sizing
//   (10 ms at 100 MHz) that all debounce blocks in this codebase agree on.
//
// Contents:
//   DEFAULT_CNT_WIDTH        default stability counter width
//   DEFAULT_DEBOUNCE_CYCLES  default number of stable cycles before commit
//   ST_*_ENC                 2-bit state encodings
//   state_t                  FSM state type built on those encodings
//   wrap_inc()               modulo-N increment used for round-robin pointers
// -----------------------------------------------------------------------------
package debounce_pkg;

  // 1_000_000 cycles = 10 ms at 100 MHz; needs 20 bits to count 0..999_999.
  localparam int DEFAULT_CNT_WIDTH       = 20;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

  // Fixed encodings so the state register is stable across tool versions and
  // can be read directly when probing the design on hardware.
  localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
  localparam logic [1:0] ST_COUNT_ENC  = 2'd1;
  localparam logic [1:0] ST_COMMIT_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_COUNT  = ST_COUNT_ENC,
    ST_COMMIT = ST_COMMIT_ENC
  } state_t;

  // Next index in a ring of n entries.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/debounce_rr_picker.sv
// -----------------------------------------------------------------------------
// debounce_rr_picker
//
// Purpose:
//   Combinational round-robin picker. Returns the first set bit of `pending`
//   found by searching upward from `rr_ptr`, wrapping modulo N_CH.
//
// Ports:
//   pending      in   N_CH          per-channel pending flags
//   rr_ptr       in   clog2(N_CH)   channel with highest priority this cycle
//   grant_valid  out  1             at least one channel is pending
//   grant_idx    out  clog2(N_CH)   chosen channel (0 when nothing pending)
// -----------------------------------------------------------------------------
module debounce_rr_picker #(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0]         pending,
  input  logic [$clog2(N_CH)-1:0] rr_ptr,
  output logic                    grant_valid,
  output logic [$clog2(N_CH)-1:0] grant_idx
);

  localparam int CH_W = $clog2(N_CH);

  // cand_idx[k] is the channel sitting k places above rr_ptr in the ring;
  // pend_rot[k] is that channel's pending flag. Rotating first turns the
  // round-robin search into a plain lowest-index priority search.
  logic [CH_W-1:0] cand_idx [N_CH];
  logic [N_CH-1:0] pend_rot;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_rot
      // One extra bit so rr_ptr + gi cannot overflow before the wrap; both
      // terms are below N_CH so a single conditional subtract is enough.
      logic [CH_W:0] sum;
      assign sum = {1'b0, rr_ptr} + (CH_W+1)'(gi);
      assign cand_idx[gi] = (sum >= (CH_W+1)'(N_CH)) ?
                            CH_W'(sum - (CH_W+1)'(N_CH)) :
                            sum[CH_W-1:0];
      assign pend_rot[gi] = pending[cand_idx[gi]];
    end
  endgenerate

  // Walk from the farthest offset down so the nearest pending channel is the
  // last assignment and therefore wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (pend_rot[k]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx[k];
      end
    end
  end

endmodule

// File: rtl/debounce_arbiter.sv
// -----------------------------------------------------------------------------
// debounce_arbiter
//
// Purpose:
//   Debounces N_CH already-synchronized button inputs with one shared
//   stability counter. A channel whose input differs from its debounced level
//   is pending; a round-robin picker hands the counter to one pending channel
//   at a time. The debounced level flips only after the input has held its new
//   value for DEBOUNCE_CYCLES consecutive cycles; any bounce back aborts the
//   attempt and passes the counter on.
//
// Ports:
//   clk        in   1             system clock, rising edge
//   reset      in   1             synchronous, active-high reset
//   sync_in    in   N_CH          synchronized raw button levels
//   btn_out    out  N_CH          debounced levels
//   btn_pulse  out  N_CH          one-cycle pulse on a committed 0->1 change
//   busy       out  1             counter currently granted (FSM not idle)
//   active_ch  out  clog2(N_CH)   channel currently owning the counter
//
// Timing (IDLE sees channel i pending in cycle t):
//   COUNT in t+1 .. t+DEBOUNCE_CYCLES, COMMIT (btn_out/btn_pulse change) in
//   t+DEBOUNCE_CYCLES+1, IDLE again in t+DEBOUNCE_CYCLES+2.
// -----------------------------------------------------------------------------
module debounce_arbiter #(
  parameter int N_CH            = 4,
  parameter int CNT_WIDTH       = debounce_pkg::DEFAULT_CNT_WIDTH,
  parameter int DEBOUNCE_CYCLES = debounce_pkg::DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         sync_in,
  output logic [N_CH-1:0]         btn_out,
  output logic [N_CH-1:0]         btn_pulse,
  output logic                    busy,
  output logic [$clog2(N_CH)-1:0] active_ch
);

  import debounce_pkg::*;

  localparam int CH_W = $clog2(N_CH);

  // Terminal count: the counter starts at 0 on the first COUNT cycle, so the
  // DEBOUNCE_CYCLES-th stable cycle is the one that sees this value.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t               state_reg;
  logic [CNT_WIDTH-1:0] cnt_reg;
  logic [N_CH-1:0]      btn_out_reg;
  logic [N_CH-1:0]      btn_pulse_reg;
  logic [CH_W-1:0]      active_ch_reg;
  logic [CH_W-1:0]      rr_ptr_reg;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic [N_CH-1:0] pending;
  logic            grant_valid;
  logic [CH_W-1:0] grant_idx;
  logic [CH_W-1:0] rr_ptr_next;
  logic            active_settled;

  // Pending is recomputed every cycle from the live inputs; nothing is
  // latched, so a channel that bounces back while waiting simply drops out.
  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_pending
      assign pending[gi] = sync_in[gi] ^ btn_out_reg[gi];
    end
  endgenerate

  // The owning channel has returned to its debounced level: a bounce.
  assign active_settled = (sync_in[active_ch_reg] == btn_out_reg[active_ch_reg]);

  // After an owner finishes (commit or abort) priority moves to the channel
  // just above it, which bounds the wait of any persistently pending channel
  // to N_CH-1 other grants.
  assign rr_ptr_next = CH_W'(wrap_inc(int'(active_ch_reg), N_CH));

  debounce_rr_picker #(
    .N_CH (N_CH)
  ) u_picker (
    .pending     (pending),
    .rr_ptr      (rr_ptr_reg),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // ---------------------------------------------------------------------------
  // FSM, shared counter, debounced outputs and round-robin pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      btn_out_reg   <= '0;
      btn_pulse_reg <= '0;
      active_ch_reg <= '0;
      rr_ptr_reg    <= '0;
    end else begin
      // The pulse is only ever set on the COUNT->COMMIT edge below, so
      // clearing it by default confines it to the single COMMIT cycle.
      btn_pulse_reg <= '0;

      case (state_reg)
        ST_IDLE: begin
          if (grant_valid) begin
            active_ch_reg <= grant_idx;
            cnt_reg       <= '0;
            state_reg     <= ST_COUNT;
          end
        end

        ST_COUNT: begin
          if (active_settled) begin
            // Bounce: give up this attempt and let the next channel in.
            cnt_reg    <= '0;
            rr_ptr_reg <= rr_ptr_next;
            state_reg  <= ST_IDLE;
          end else if (cnt_reg == CNT_LAST) begin
            // Held long enough. The new level is the inverse of the old one,
            // so the pulse bit is set exactly when the level rises.
            btn_out_reg[active_ch_reg]   <= ~btn_out_reg[active_ch_reg];
            btn_pulse_reg[active_ch_reg] <= ~btn_out_reg[active_ch_reg];
            state_reg                    <= ST_COMMIT;
          end else begin
            cnt_reg <= cnt_reg + CNT_WIDTH'(1);
          end
        end

        ST_COMMIT: begin
          rr_ptr_reg <= rr_ptr_next;
          cnt_reg    <= '0;
          state_reg  <= ST_IDLE;
        end

        default: begin
          cnt_reg   <= '0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign btn_out   = btn_out_reg;
  assign btn_pulse = btn_pulse_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign active_ch = active_ch_reg;

endmodule

// File: tb/tb_debounce_arbiter.sv
// -----------------------------------------------------------------------------
// tb_debounce_arbiter
//
// Directed bench for debounce_arbiter with N_CH=4, DEBOUNCE_CYCLES=8.
// Cycle numbering: cycle 0 is the first cycle after reset deasserts; inputs
// are driven and outputs sampled 1 ns after each rising edge. Expected values
// are hand-derived from the cycle timing of the arbiter.
// -----------------------------------------------------------------------------
module tb_debounce_arbiter;

  localparam int N_CH = 4;
  localparam int CNT_W = 4;
  localparam int DEB = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] sync_in = 4'b0000;
  logic [3:0] btn_out;
  logic [3:0] btn_pulse;
  logic       busy;
  logic [1:0] active_ch;

  int cyc;
  int n_vec;
  int n_err;

  debounce_arbiter #(
    .N_CH            (N_CH),
    .CNT_WIDTH       (CNT_W),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sync_in   (sync_in),
    .btn_out   (btn_out),
    .btn_pulse (btn_pulse),
    .busy      (busy),
    .active_ch (active_ch)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Hold reset for two edges, then release it and apply s: this is cycle 0.
  task automatic start(input logic [3:0] s);
    reset   = 1'b1;
    sync_in = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    reset   = 1'b0;
    sync_in = s;
    cyc     = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rise;
    logic ch0_bad;
    n_vec = 0;
    n_err = 0;
    cyc   = 0;

    // ---------------- Single press ----------------
    start(4'b0001);
    check("rst_btn_out",   btn_out,   0);
    check("rst_btn_pulse", btn_pulse, 0);
    check("rst_busy",      busy,      0);
    check("rst_active_ch", active_ch, 0);
    for (int c = 1; c <= 10; c++) begin
      step();
      check("sp_busy",  busy,      (c <= 9) ? 32'd1 : 32'd0);
      check("sp_out",   btn_out,   (c >= 9) ? 32'd1 : 32'd0);
      check("sp_pulse", btn_pulse, (c == 9) ? 32'd1 : 32'd0);
    end
    $display("txn single_press   end_cycle=%0d btn_out=%b", cyc, btn_out);

    // ---------------- Bounce abort, then hold ----------------
    start(4'b0001);
    for (int c = 1; c <= 16; c++) begin
      step();
      check("ba_busy",  busy,      ((c <= 5) || (c >= 7 && c <= 15)) ? 32'd1 : 32'd0);
      check("ba_out",   btn_out,   (c >= 15) ? 32'd1 : 32'd0);
      check("ba_pulse", btn_pulse, (c == 15) ? 32'd1 : 32'd0);
      if (c == 7) check("ba_regrant_ch", active_ch, 0);
      if (c == 5) sync_in = 4'b0000;
      if (c == 6) sync_in = 4'b0001;
    end
    $display("txn bounce_abort   end_cycle=%0d btn_out=%b", cyc, btn_out);

    // ---------------- Simultaneous press ----------------
    start(4'b1010);
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 1)  check("sim_first_ch", active_ch, 1);
      if (c == 9)  check("sim_out1",     btn_out,   32'b0010);
      if (c == 9)  check("sim_pulse1",   btn_pulse, 32'b0010);
      if (c == 10) check("sim_idle",     busy,      0);
      if (c == 11) check("sim_busy3",    busy,      1);
      if (c == 11) check("sim_second_ch", active_ch, 3);
      if (c == 18) check("sim_out_pre3", btn_out,   32'b0010);
      if (c == 19) check("sim_out3",     btn_out,   32'b1010);
      if (c == 19) check("sim_pulse3",   btn_pulse, 32'b1000);
      if (c == 20) check("sim_pulse_end", btn_pulse, 0);
      if (c == 20) check("sim_idle_end", busy,      0);
    end
    $display("txn simultaneous   end_cycle=%0d btn_out=%b", cyc, btn_out);

    // ---------------- Release ----------------
    start(4'b0100);
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 9)  check("rel_press_out", btn_out, 32'b0100);
      if (c == 10) sync_in = 4'b0000;
      if (c >= 10) begin
        check("rel_out",   btn_out,   (c >= 19) ? 32'b0000 : 32'b0100);
        check("rel_pulse", btn_pulse, 0);
      end
      if (c == 11) check("rel_ch", active_ch, 2);
    end
    $display("txn release        end_cycle=%0d btn_out=%b", cyc, btn_out);

    // ---------------- Reset mid-COUNT and mid-COMMIT ----------------
    start(4'b0001);
    for (int c = 1; c <= 15; c++) begin
      step();
      if (c == 4) begin
        check("rm_busy_before", busy, 1);
        reset = 1'b1;
      end
      if (c == 5) begin
        check("rm_out",    btn_out,   0);
        check("rm_pulse",  btn_pulse, 0);
        check("rm_busy",   busy,      0);
        check("rm_active", active_ch, 0);
        reset = 1'b0;
      end
      if (c == 13) check("rm_out_pre", btn_out, 0);
      if (c == 14) begin
        check("rm_out_commit",   btn_out,   1);
        check("rm_pulse_commit", btn_pulse, 1);
        reset = 1'b1;
      end
      if (c == 15) begin
        check("rc_out",   btn_out,   0);
        check("rc_pulse", btn_pulse, 0);
        check("rc_busy",  busy,      0);
      end
    end
    $display("txn reset_mid     end_cycle=%0d btn_out=%b", cyc, btn_out);

    // ---------------- Fairness ----------------
    start(4'b0101);
    rise    = -1;
    ch0_bad = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      step();
      sync_in[0] = ((c / 3) % 2 == 0);
      if (btn_out[2] && rise < 0) rise = c;
      if (btn_out[0] || btn_pulse[0]) ch0_bad = 1'b1;
    end
    check("fair_rise_cycle", rise, 13);
    check("fair_within",     (rise > 0 && rise <= 2 * (DEB + 2)) ? 32'd1 : 32'd0, 1);
    check("fair_ch0_never",  ch0_bad, 0);
    check("fair_out2",       btn_out[2], 1);
    $display("txn fairness       end_cycle=%0d btn_out=%b rise=%0d", cyc, btn_out, rise);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
